spram_bus_ctrl: RTL and testbench

- Bus-side controller in front of the 128 KB SPRAM macro (spram_32kx32).
- Converts the CPU native memory handshake (mem_valid/mem_ready, byte strobes) into single-cycle SPRAM select/write strobes.
- Absorbs the SPRAM's one-cycle read latency and registers returned read data.
- Optionally zero-fills the whole RAM after reset before the CPU is allowed in.

---
 rtl/spram_bus_ctrl.sv | 135 +++++++++++++
 tb/tb_spram_bus_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spram_bus_ctrl.sv
// spram_bus_ctrl: CPU native memory handshake to single-cycle SPRAM strobes, with registered read data.
// Define SPRAM_BOOT_CLEAR_EN to zero-fill CLEAR_WORDS words after reset before the CPU is let in.
module spram_bus_ctrl #(
    parameter int CLEAR_WORDS = 32768
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [16:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        ram_sel,
    output logic [3:0]  ram_we,
    output logic [16:0] ram_addr,
    output logic [31:0] ram_wdat,
    input  logic [31:0] ram_rdat,
    output logic        busy
);

    if (CLEAR_WORDS < 1 || CLEAR_WORDS > 32768) begin : g_bad_clear_words
        $error("spram_bus_ctrl: CLEAR_WORDS must be within 1..32768");
    end

`ifdef SPRAM_BOOT_CLEAR_EN
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RDATA = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam state_t      RESET_STATE = ST_CLEAR;
    localparam logic [14:0] CLR_LAST    = 15'(CLEAR_WORDS - 1);

    logic [14:0] clr_cnt_q;
    logic [14:0] clr_cnt_d;
    logic        busy_q;

    assign clr_cnt_d = clr_cnt_q + 15'd1;
    assign busy      = busy_q;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd1,
        ST_RDATA = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam state_t RESET_STATE = ST_IDLE;

    assign busy = 1'b0;
`endif

    state_t      state_q;
    logic        bubble_q;
    logic        mem_ready_q;
    logic [31:0] mem_rdata_q;
    logic        idle_take;

    // The bubble after ACK gives the master one cycle to drop mem_valid.
    assign idle_take = (state_q == ST_IDLE) && !bubble_q && mem_valid;

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

    always_comb begin
        ram_sel  = 1'b0;
        ram_we   = 4'h0;
        ram_addr = mem_addr;
        ram_wdat = mem_wdata;
        if (idle_take) begin
            ram_sel = 1'b1;
            ram_we  = mem_wstrb;
        end
`ifdef SPRAM_BOOT_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            ram_sel  = 1'b1;
            ram_we   = 4'hF;
            ram_addr = {clr_cnt_q, 2'b00};
            ram_wdat = 32'h0;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RESET_STATE;
            bubble_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0;
`ifdef SPRAM_BOOT_CLEAR_EN
            busy_q      <= 1'b1;
            clr_cnt_q   <= 15'd0;
`endif
        end else begin
            mem_ready_q <= 1'b0;
            bubble_q    <= 1'b0;
            case (state_q)
`ifdef SPRAM_BOOT_CLEAR_EN
                ST_CLEAR: begin
                    // Terminal compare precedes the increment so the counter never wraps.
                    if (clr_cnt_q == CLR_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_d;
                    end
                end
`endif
                ST_IDLE: begin
                    if (idle_take) begin
                        if (mem_wstrb != 4'h0) begin
                            mem_ready_q <= 1'b1;
                            state_q     <= ST_ACK;
                        end else begin
                            state_q <= ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    mem_rdata_q <= ram_rdat;
                    mem_ready_q <= 1'b1;
                    state_q     <= ST_ACK;
                end
                ST_ACK: begin
                    bubble_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_bus_ctrl.sv
// Directed bench for spram_bus_ctrl with a behavioural SPRAM model; follows SPRAM_BOOT_CLEAR_EN if defined.
module tb_spram_bus_ctrl;
    localparam int CW = 16;
`ifdef SPRAM_BOOT_CLEAR_EN
    localparam logic CLR_EN = 1'b1;
`else
    localparam logic CLR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [16:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        ram_sel;
    logic [3:0]  ram_we;
    logic [16:0] ram_addr;
    logic [31:0] ram_wdat;
    logic [31:0] ram_rdat = '0;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    spram_bus_ctrl #(.CLEAR_WORDS(CW)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .ram_sel(ram_sel), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdat(ram_wdat), .ram_rdat(ram_rdat), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural spram_32kx32: byte writes, one-cycle read latency.
    logic [31:0] ram [0:32767];
    always @(posedge clk) begin
        if (ram_sel) begin
            if (ram_we == 4'h0)
                ram_rdat <= ram[ram_addr[16:2]];
            else
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) ram[ram_addr[16:2]][b*8 +: 8] <= ram_wdat[b*8 +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with the controller idle; returns on a falling edge, idle again.
    task automatic do_req(input string tag, input logic [16:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int exp_lat, output logic [31:0] rd);
        int n;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_valid = 1'b1;
        #1;
        check_eq({tag, "_sel"}, {31'h0, ram_sel}, 32'h1);
        check_eq({tag, "_we"}, {28'h0, ram_we}, {28'h0, s});
        check_eq({tag, "_addr"}, {15'h0, ram_addr}, {15'h0, a});
        check_eq({tag, "_wdat"}, ram_wdat, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_ready !== 1'b1 && n < 12);
        check_eq({tag, "_lat"}, n, exp_lat);
        rd = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] last_rd;
        int n, t, bf, rt, bad;

        #1 resetn = 1'b0;
        #2;
        check_eq("rst_ready", {31'h0, mem_ready}, 32'h0);
        check_eq("rst_rdata", mem_rdata, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, {31'h0, CLR_EN});
        check_eq("rst_sel", {31'h0, ram_sel}, {31'h0, CLR_EN});
        @(negedge clk);
        resetn = 1'b1;

`ifdef SPRAM_BOOT_CLEAR_EN
        for (int i = 0; i < CW; i++) begin
            #1;
            check_eq($sformatf("clr%0d_busy", i), {31'h0, busy}, 32'h1);
            check_eq($sformatf("clr%0d_we", i), {28'h0, ram_we}, 32'hF);
            check_eq($sformatf("clr%0d_addr", i), {15'h0, ram_addr}, i * 4);
            check_eq($sformatf("clr%0d_wdat", i), ram_wdat, 32'h0);
            @(negedge clk);
        end
        #1;
        check_eq("clr_done_busy", {31'h0, busy}, 32'h0);
        check_eq("clr_done_sel", {31'h0, ram_sel}, 32'h0);
        @(negedge clk);
        do_req("clr_rd", 17'h0000C, 32'h0, 4'h0, 2, rd);
        check_eq("clr_rd_data", rd, 32'h0);
`else
        #1;
        check_eq("noclr_busy", {31'h0, busy}, 32'h0);
        check_eq("noclr_sel", {31'h0, ram_sel}, 32'h0);
        @(negedge clk);
`endif

        do_req("wr1", 17'h01000, 32'hDEADBEEF, 4'hF, 1, rd);
        do_req("rd1", 17'h01000, 32'h0, 4'h0, 2, rd);
        check_eq("rd1_data", rd, 32'hDEADBEEF);

        do_req("wrb", 17'h01000, 32'h0000AA00, 4'b0010, 1, rd);
        do_req("rdb", 17'h01000, 32'h0, 4'h0, 2, rd);
        check_eq("rdb_data", rd, 32'hDEADAAEF);
        last_rd = rd;

        do_req("wr_lo", 17'h0FFFC, 32'h11111111, 4'hF, 1, rd);
        check_eq("rdata_hold", mem_rdata, last_rd);
        do_req("wr_hi", 17'h10000, 32'h22222222, 4'hF, 1, rd);
        do_req("rd_lo", 17'h0FFFC, 32'h0, 4'h0, 2, rd);
        check_eq("rd_lo_data", rd, 32'h11111111);
        do_req("rd_hi", 17'h10000, 32'h0, 4'h0, 2, rd);
        check_eq("rd_hi_data", rd, 32'h22222222);

        // Back-to-back writes with mem_valid held: the bubble spaces them 3 cycles apart.
        mem_addr = 17'h02040; mem_wdata = 32'h33333333; mem_wstrb = 4'hF; mem_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (mem_ready !== 1'b1 && n < 12);
        check_eq("b2b_first_lat", n, 1);
        mem_addr = 17'h02044; mem_wdata = 32'h44444444;
        @(negedge clk);
        #1;
        check_eq("bubble_sel", {31'h0, ram_sel}, 32'h0);
        n = 1;
        do begin @(negedge clk); n++; end while (mem_ready !== 1'b1 && n < 12);
        check_eq("b2b_spacing", n, 3);
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        @(negedge clk);
        @(negedge clk);
        do_req("rd_b2b1", 17'h02040, 32'h0, 4'h0, 2, rd);
        check_eq("rd_b2b1_data", rd, 32'h33333333);
        do_req("rd_b2b2", 17'h02044, 32'h0, 4'h0, 2, rd);
        check_eq("rd_b2b2_data", rd, 32'h44444444);

        // Master drops mem_valid right after issue; the read still completes.
        mem_addr = 17'h01000; mem_wstrb = 4'h0; mem_valid = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        n = 1;
        while (mem_ready !== 1'b1 && n < 12) begin @(negedge clk); n++; end
        check_eq("drop_lat", n, 2);
        check_eq("drop_data", mem_rdata, 32'hDEADAAEF);
        @(negedge clk);
        @(negedge clk);

        do_req("wr_w3", 17'h0000C, 32'h12345678, 4'hF, 1, rd);

        // Request raised during the boot clear waits for busy to fall.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        mem_addr = 17'h02000; mem_wdata = 32'hCAFEF00D; mem_wstrb = 4'hF; mem_valid = 1'b1;
        bf = -1; rt = -1; bad = 0; t = 0;
        while (rt < 0 && t < 40) begin
            #1;
            if (!busy && bf < 0) bf = t;
            if (mem_ready) rt = t;
            if (mem_ready && busy) bad++;
            if (rt < 0) begin
                @(negedge clk);
                t++;
            end
        end
        check_eq("clrwait_busy_fall", bf, CLR_EN ? CW : 0);
        check_eq("clrwait_lat", rt, bf + 1);
        check_eq("clrwait_ready_busy", bad, 0);
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        @(negedge clk);
        @(negedge clk);
        do_req("rd_cw", 17'h02000, 32'h0, 4'h0, 2, rd);
        check_eq("rd_cw_data", rd, 32'hCAFEF00D);
        do_req("rd_w3", 17'h0000C, 32'h0, 4'h0, 2, rd);
        check_eq("rd_w3_data", rd, CLR_EN ? 32'h0 : 32'h12345678);
        do_req("rd_pre", 17'h01000, 32'h0, 4'h0, 2, rd);
        check_eq("rd_pre_data", rd, 32'hDEADAAEF);

        // Async reset while in RDATA drops the read.
        mem_addr = 17'h01000; mem_wstrb = 4'h0; mem_valid = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check_eq("rrst_ready", {31'h0, mem_ready}, 32'h0);
        check_eq("rrst_rdata", mem_rdata, 32'h0);
        check_eq("rrst_busy", {31'h0, busy}, {31'h0, CLR_EN});
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_eq("rrst_sel", {31'h0, ram_sel}, {31'h0, CLR_EN});
        check_eq("rrst_addr", {15'h0, ram_addr}, CLR_EN ? 32'h0 : 32'h1000);
        bad = 0;
        for (int i = 0; i < CW + 6; i++) begin
            @(negedge clk);
            if (mem_ready) bad++;
        end
        check_eq("rrst_no_ready", bad, 0);
        check_eq("rrst_rdata_after", mem_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
